adder_tree_acc: RTL and testbench
=================================

// Module: adder_tree_acc
// PURPOSE
//  Parametrised, pipelined signed adder tree that reduces N_IN products from the
//  conv multiplier array to one sum per cycle. Adds valid tracking, multi-pass
//  channel accumulation (first/last framing) and optional saturation.
//  Sits between the multiplier array and the output/activation stage.
// PARAMETERS
//  N_IN   25  number of signed product inputs (>=2)
//  IN_W   16  width of each product, two's complement
//  ACC_W  32  accumulator/output width (>= IN_W+clog2(N_IN))
//  SAT    1   1: accumulator clamps at ACC_W limits; 0: wraps modulo 2^ACC_W
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  flush      in   1           sync clear of all valids and group state
//  in_valid   in   1           prods beat valid this cycle
//  in_first   in   1           beat starts a new accumulation group
//  in_last    in   1           beat closes the group; result emitted
//  prods      in   N_IN*IN_W   packed products, p[i] = prods[i*IN_W +: IN_W]
//  out_valid  out  1           one-cycle pulse: out_sum is a group result
//  out_sum    out  ACC_W       signed group sum
//  out_ovf    out  1           group saturated/wrapped; qualified by out_valid
// BEHAVIOUR
//  - Reset (rst_n=0, async): every register 0; out_valid=0, out_sum=0, out_ovf=0.
//  - Tree: L=clog2(N_IN) registered levels. Each level pairs adjacent entries
//    (2i, 2i+1). An odd leftover is sign-extended and registered unpaired.
//    Level k width = IN_W+k, so tree sums never overflow.
//  - A valid bit, first bit and last bit run in a shift register beside the data.
//    Data regs load every cycle; only tagged beats are acted on.
//  - Accumulator stage, 1 cycle after the tree; total latency L+1.
//    N_IN=25: L=5, out_valid 6 cycles after an in_valid+in_last beat.
//  - One beat per cycle, no backpressure; downstream must accept every pulse.
//  - Group FSM, states IDLE and ACCUM, evaluated on valid beats at the acc stage:
//    IDLE : beat loads acc=sext(tree). !last -> ACCUM; last -> emit, stay IDLE.
//           A beat here is a group start even if first=0.
//    ACCUM: first=1 discards the open group and reloads acc=sext(tree).
//           first=0 adds the tree sum to acc. last=1 -> emit, go IDLE.
//    first=last=1: single-beat group, emitted directly.
//  - Emit: out_sum=acc result, out_valid=1 for one cycle, out_ovf=group sticky.
//    out_sum and out_ovf hold until the next emit; out_valid is 0 otherwise.
//  - Overflow: true signed add overflow at ACC_W sets the sticky flag.
//    Flag clears on group start.
//    SAT=1: result clamps to +2^(ACC_W-1)-1 / -2^(ACC_W-1).
//    SAT=0: result wraps modulo 2^ACC_W.
//  - Invalid cycles: accumulator and FSM hold.
//  - flush=1: all pipeline valid bits and the FSM clear next edge, acc=0,
//    out_valid=0, in-flight beats are dropped.
//    An in_valid in the same cycle as flush is also dropped.
//    out_sum and out_ovf keep their last values.
//  - Async reset mid-group: everything cleared, nothing emitted afterwards.
//    First post-reset valid beat starts a new group.
// TESTING
//  1 N_IN=25, all p=1, in_first=in_last=1
//    -> out_valid at cycle +6, out_sum=25, out_ovf=0.
//  2 all p=-32768, single-beat group -> out_sum=-819200, out_ovf=0.
//  3 Accumulate 3 back-to-back beats of all p=100, first on beat0, last on beat2
//    -> one pulse, out_sum=7500, 2 cycles after single-beat timing.
//  4 ACC_W=24, SAT=1: 11 beats of all p=32767
//    -> out_sum=8388607, out_ovf=1; repeat with SAT=0: wrapped value, out_ovf=1.
//  5 Open group of 2 beats, then beat with first=1,last=1 of all p=2
//    -> out_sum=50, only one pulse.
//  6 Flush mid-group, then reset mid-group -> no pulse from the dropped beats.
//    Next single beat of all p=1 -> 25.

Source files
------------

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree reducing N_IN products per beat,
// followed by a first/last framed group accumulator with optional saturation.
module adder_tree_acc #(
   parameter int N_IN  = 25,
   parameter int IN_W  = 16,
   parameter int ACC_W = 32,
   parameter bit SAT   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [N_IN*IN_W-1:0]     prods,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_sum,
   output logic                     out_ovf
);

   function automatic int cnt_at(input int k);
      int n;
      n = N_IN;
      for (int j = 0; j < k; j++) begin
         n = (n + 1) / 2;
      end
      return n;
   endfunction

   localparam int L  = $clog2(N_IN);
   localparam int TW = IN_W + L;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // Every tree node viewed sign-extended to the final tree width.
   logic signed [TW-1:0] node_s [0:L][0:N_IN-1];

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign node_s[0][i] = TW'($signed(prods[i*IN_W +: IN_W]));
   end

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int NP = cnt_at(k - 1);
      localparam int NC = cnt_at(k);
      localparam int LW = IN_W + k;
      for (genvar i = 0; i < N_IN; i++) begin : g_node
         if (i < NC) begin : g_used
            logic signed [LW-1:0] sum_d;
            logic signed [LW-1:0] sum_q;
            if (2 * i + 1 < NP) begin : g_pair
               assign sum_d = LW'(node_s[k-1][2*i]) + LW'(node_s[k-1][2*i+1]);
            end else begin : g_odd
               assign sum_d = LW'(node_s[k-1][2*i]);
            end
            // Tree level register; loads every cycle, beats are qualified by the tag pipe.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  sum_q <= '0;
               end else begin
                  sum_q <= sum_d;
               end
            end
            assign node_s[k][i] = TW'(sum_q);
         end else begin : g_unused
            assign node_s[k][i] = '0;
         end
      end
   end

   logic [L-1:0] vld_q, vld_d;
   logic [L-1:0] fst_q, fst_d;
   logic [L-1:0] lst_q, lst_d;

   // Tag shift register next state; flush drops every in-flight beat.
   always_comb begin
      if (flush) begin
         vld_d = '0;
      end else begin
         vld_d = L'({vld_q, in_valid});
      end
      fst_d = L'({fst_q, in_first});
      lst_d = L'({lst_q, in_last});
   end

   // Tag shift register running beside the tree data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q <= vld_d;
         fst_q <= fst_d;
         lst_q <= lst_d;
      end
   end

   logic                     beat_s;
   logic                     fst_s;
   logic                     lst_s;
   logic signed [ACC_W-1:0]  tree_ext_s;
   logic signed [ACC_W:0]    sum_wide_s;
   logic signed [ACC_W-1:0]  add_res_s;
   logic                     add_ovf_s;

   assign beat_s     = vld_q[L-1] & ~flush;
   assign fst_s      = fst_q[L-1];
   assign lst_s      = lst_q[L-1];
   assign tree_ext_s = ACC_W'(node_s[L][0]);

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     sticky_q, sticky_d;
   logic                     emit_d;

   // Accumulate with one guard bit; a mismatch of the top two bits is true signed overflow.
   always_comb begin
      sum_wide_s = {acc_q[ACC_W-1], acc_q} + {tree_ext_s[ACC_W-1], tree_ext_s};
      if (sum_wide_s[ACC_W] != sum_wide_s[ACC_W-1]) begin
         add_ovf_s = 1'b1;
         if (SAT) begin
            add_res_s = sum_wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
         end else begin
            add_res_s = sum_wide_s[ACC_W-1:0];
         end
      end else begin
         add_ovf_s = 1'b0;
         add_res_s = sum_wide_s[ACC_W-1:0];
      end
   end

   // Group FSM next state.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else if (beat_s) begin
         case (state_q)
            ST_IDLE:  state_d = lst_s ? ST_IDLE : ST_ACCUM;
            ST_ACCUM: state_d = lst_s ? ST_IDLE : ST_ACCUM;
            default:  state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Group FSM outputs: accumulator load/add, sticky overflow and emit strobe.
   always_comb begin
      acc_d    = acc_q;
      sticky_d = sticky_q;
      emit_d   = 1'b0;
      if (flush) begin
         acc_d    = '0;
         sticky_d = 1'b0;
      end else if (beat_s) begin
         if ((state_q == ST_IDLE) || fst_s) begin
            acc_d    = tree_ext_s;
            sticky_d = 1'b0;
         end else begin
            acc_d    = add_res_s;
            sticky_d = sticky_q | add_ovf_s;
         end
         emit_d = lst_s;
      end else begin
         acc_d    = acc_q;
         sticky_d = sticky_q;
      end
   end

   // Group state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
      end
   end

   // Result registers; sum and flag hold between emits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= emit_d;
         if (emit_d) begin
            out_sum <= acc_d;
            out_ovf <= sticky_d;
         end else begin
            out_sum <= out_sum;
            out_ovf <= out_ovf;
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed beats into three adder_tree_acc instances
// (32-bit saturating, 24-bit saturating, 24-bit wrapping) with a queue scoreboard.
module tb_adder_tree_acc;
   localparam int N_IN = 25;
   localparam int IN_W = 16;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    flush;
   logic                    in_valid;
   logic                    in_first;
   logic                    in_last;
   logic [N_IN*IN_W-1:0]    prods;

   logic                    ov0, ov1, ov2;
   logic signed [31:0]      os0;
   logic signed [23:0]      os1, os2;
   logic                    of0, of1, of2;

   always #5 clk = ~clk;

   adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(32), .SAT(1'b1)) u_d32s (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .prods(prods), .out_valid(ov0), .out_sum(os0), .out_ovf(of0));
   adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(24), .SAT(1'b1)) u_d24s (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .prods(prods), .out_valid(ov1), .out_sum(os1), .out_ovf(of1));
   adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(24), .SAT(1'b0)) u_d24w (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .prods(prods), .out_valid(ov2), .out_sum(os2), .out_ovf(of2));

   typedef struct {
      string name;
      int    sum;
      bit    ovf;
      int    cyc;
   } exp_t;

   exp_t  q0[$];
   exp_t  q1[$];
   exp_t  q2[$];
   int    cyc      = 0;
   int    n_tests  = 0;
   int    n_fail   = 0;
   int    last_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect3(input string nm, input int e32, input bit o32,
                          input int e24s, input bit o24s, input int e24w, input bit o24w);
      exp_t e;
      e.name = nm; e.cyc = last_cyc + 6;
      e.sum = e32;  e.ovf = o32;  q0.push_back(e);
      e.sum = e24s; e.ovf = o24s; q1.push_back(e);
      e.sum = e24w; e.ovf = o24w; q2.push_back(e);
   endtask

   task automatic check_pulse(input int id, input int sum, input bit ovf);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (id)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      n_tests++;
      if (!have) begin
         n_fail++;
         $display("FAIL unexpected_pulse dut%0d: got sum=%0d ovf=%0d at cyc=%0d, required no pulse",
                  id, sum, ovf, cyc);
      end else if (sum !== e.sum || ovf !== e.ovf || cyc !== e.cyc) begin
         n_fail++;
         $display("FAIL %s dut%0d: got sum=%0d ovf=%0d cyc=%0d, required sum=%0d ovf=%0d cyc=%0d",
                  e.name, id, sum, ovf, cyc, e.sum, e.ovf, e.cyc);
      end
   endtask

   // Monitor: every output pulse pops and checks the head of its scoreboard queue.
   always @(negedge clk) begin
      if (ov0 === 1'b1) check_pulse(0, int'(os0), of0);
      if (ov1 === 1'b1) check_pulse(1, int'(os1), of1);
      if (ov2 === 1'b1) check_pulse(2, int'(os2), of2);
   end

   task automatic check_out(input string nm, input int id, input logic v, input int sum,
                            input logic ovf, input int e_sum);
      n_tests++;
      if (v !== 1'b0 || sum !== e_sum || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL %s dut%0d: got valid=%b sum=%0d ovf=%b, required valid=0 sum=%0d ovf=0",
                  nm, id, v, sum, ovf, e_sum);
      end
   endtask

   task automatic set_all(input int p);
      for (int i = 0; i < N_IN; i++) begin
         prods[i*IN_W +: IN_W] = 16'(p);
      end
   endtask

   task automatic beat(input int p, input bit f, input bit l);
      set_all(p);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      last_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_empty(input int id, input int sz);
      n_tests++;
      if (sz != 0) begin
         n_fail++;
         $display("FAIL missing_pulse dut%0d: got %0d expected results never emitted, required 0", id, sz);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      prods = '0;
      idle(3);
      check_out("reset_state", 0, ov0, int'(os0), of0, 0);
      check_out("reset_state", 1, ov1, int'(os1), of1, 0);
      check_out("reset_state", 2, ov2, int'(os2), of2, 0);
      rst_n = 1'b1;
      idle(2);

      // 1: single-beat group of ones
      beat(1, 1'b1, 1'b1);
      expect3("single_ones", 25, 1'b0, 25, 1'b0, 25, 1'b0);
      idle(8);

      // 2: most negative products
      beat(-32768, 1'b1, 1'b1);
      expect3("single_min", -819200, 1'b0, -819200, 1'b0, -819200, 1'b0);
      idle(8);

      // 3: three back-to-back beats
      beat(100, 1'b1, 1'b0);
      beat(100, 1'b0, 1'b0);
      beat(100, 1'b0, 1'b1);
      expect3("accum3", 7500, 1'b0, 7500, 1'b0, 7500, 1'b0);
      idle(8);

      // 4: 11 beats of max products, overflows only the 24-bit instances
      for (int b = 0; b < 11; b++) begin
         beat(32767, (b == 0), (b == 10));
      end
      expect3("accum11_ovf", 9010925, 1'b0, 8388607, 1'b1, -7766291, 1'b1);
      idle(8);

      // 5: open group discarded by a first+last beat
      beat(7, 1'b1, 1'b0);
      beat(7, 1'b0, 1'b0);
      beat(2, 1'b1, 1'b1);
      expect3("restart", 50, 1'b0, 50, 1'b0, 50, 1'b0);
      idle(8);

      // 6a: beat presented together with flush is dropped
      flush = 1'b1;
      beat(5, 1'b1, 1'b1);
      flush = 1'b0;
      idle(8);

      // 6b: flush an open group with its closing beat in flight
      beat(3, 1'b1, 1'b0);
      beat(3, 1'b0, 1'b0);
      idle(8);
      beat(3, 1'b0, 1'b1);
      idle(2);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(8);
      check_out("flush_hold", 0, ov0, int'(os0), of0, 50);
      beat(1, 1'b0, 1'b1);
      expect3("after_flush", 25, 1'b0, 25, 1'b0, 25, 1'b0);
      idle(8);

      // 6c: async reset with an open group and its closing beat in flight
      beat(4, 1'b1, 1'b0);
      idle(8);
      beat(4, 1'b0, 1'b1);
      idle(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("midreset", 0, ov0, int'(os0), of0, 0);
      check_out("midreset", 1, ov1, int'(os1), of1, 0);
      check_out("midreset", 2, ov2, int'(os2), of2, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(8);
      beat(1, 1'b0, 1'b1);
      expect3("after_reset", 25, 1'b0, 25, 1'b0, 25, 1'b0);
      idle(20);

      check_empty(0, q0.size());
      check_empty(1, q1.size());
      check_empty(2, q2.size());
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
